// File: rtl/serial_to_parallel_rx.sv
// Serial lane receiver: hunts for the idle comma to find byte alignment, locks after
// LOCK_COUNT aligned commas, then delivers recovered bytes with a valid flag.
module serial_to_parallel_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       data_stb,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;

    logic boundary;
    logic is_comma;

    assign boundary = (bit_cnt_q == 3'd0);
    assign is_comma = (sr_q == COMMA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
        end
    end

    always_comb begin
        sr_d      = {sr_q[6:0], data_in};
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;

        case (state_q)
            SEARCH: begin
                // bit_cnt=1 here puts the next boundary exactly one byte after this comma
                if (is_comma) begin
                    bc_cnt_d  = 4'd1;
                    bit_cnt_d = 3'd1;
                    state_d   = (LOCK_TARGET == 4'd1) ? ACTIVE : LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if ((bc_cnt_q + 4'd1) == LOCK_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        bc_cnt_d = 4'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d  = sr_q;
                    valid_d = !is_comma;
                    stb_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign data_stb  = stb_q;
    assign active    = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: lock, data recovery, comma slots,
// phase offset, broken lock and asynchronous reset.
module tb_serial_to_parallel_rx;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       data_stb;
    logic       active;

    int total;
    int bad;
    int cyc;

    logic [7:0] q_data[$];
    logic       q_valid[$];
    int         q_cyc[$];
    bit         act_seen;
    int         act_cyc;

    serial_to_parallel_rx #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .data_stb (data_stb),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe/active event log, sampled mid-cycle
    always @(negedge clk) begin
        if (data_stb) begin
            q_data.push_back(data_out);
            q_valid.push_back(valid_out);
            q_cyc.push_back(cyc);
        end
        if (active && !act_seen) begin
            act_seen = 1'b1;
            act_cyc  = cyc;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic clear_log();
        q_data.delete();
        q_valid.delete();
        q_cyc.delete();
        act_seen = 1'b0;
        act_cyc  = -1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_in = 1'b0;
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(8'hFF);
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        total++;
        if (data_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", data_stb); end
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
        for (int i = 0; i < 5; i++) send_byte(8'hBC);
        send_bit(1'b0);
        total++;
        if (active !== 1'b0 || act_seen) begin bad++; $display("FAIL reset_comma_no_lock got=%b exp=0", active); end
        total++;
        if (q_data.size() != 0) begin bad++; $display("FAIL reset_no_stb got=%0d exp=0", q_data.size()); end
    endtask

    task automatic test_clean_lock();
        int n;
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", active); end
        send_byte(8'hBC);
        n = cyc;
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL lock_at_4th got=%b exp=0", active); end
        send_byte(8'hAA);
        send_byte(8'hEE);
        send_byte(8'hEE);
        send_byte(8'hBC);
        total++;
        if (act_cyc != n + 1) begin bad++; $display("FAIL lock_active_time got=%0d exp=%0d", act_cyc, n + 1); end
        total++;
        if (q_data.size() != 3) begin
            bad++; $display("FAIL lock_stb_count got=%0d exp=3", q_data.size());
        end else begin
            total++;
            if (q_data[0] !== 8'hAA || q_valid[0] !== 1'b1 || q_cyc[0] != n + 9) begin
                bad++; $display("FAIL lock_byte0 got=%h/%b@%0d exp=aa/1@%0d", q_data[0], q_valid[0], q_cyc[0], n + 9);
            end
            total++;
            if (q_data[1] !== 8'hEE || q_valid[1] !== 1'b1 || q_cyc[1] != n + 17) begin
                bad++; $display("FAIL lock_byte1 got=%h/%b@%0d exp=ee/1@%0d", q_data[1], q_valid[1], q_cyc[1], n + 17);
            end
            total++;
            if (q_data[2] !== 8'hEE || q_valid[2] !== 1'b1 || q_cyc[2] != n + 25) begin
                bad++; $display("FAIL lock_byte2 got=%h/%b@%0d exp=ee/1@%0d", q_data[2], q_valid[2], q_cyc[2], n + 25);
            end
        end
    endtask

    // trailing BC from the previous test is the invalid slot; BB follows it
    task automatic test_invalid_slot();
        clear_log();
        send_byte(8'hBB);
        send_byte(8'hBC);
        total++;
        if (q_data.size() != 2) begin
            bad++; $display("FAIL slot_stb_count got=%0d exp=2", q_data.size());
        end else begin
            total++;
            if (q_data[0] !== 8'hBC || q_valid[0] !== 1'b0) begin
                bad++; $display("FAIL slot_comma got=%h/%b exp=bc/0", q_data[0], q_valid[0]);
            end
            total++;
            if (q_data[1] !== 8'hBB || q_valid[1] !== 1'b1 || q_cyc[1] != q_cyc[0] + 8) begin
                bad++; $display("FAIL slot_data got=%h/%b gap=%0d exp=bb/1 gap=8", q_data[1], q_valid[1], q_cyc[1] - q_cyc[0]);
            end
        end
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL slot_active got=%b exp=1", active); end
    endtask

    task automatic test_phase_offset();
        int n;
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        n = cyc;
        send_byte(8'hAA);
        send_byte(8'hBC);
        total++;
        if (act_cyc != n + 1) begin bad++; $display("FAIL phase_active_time got=%0d exp=%0d", act_cyc, n + 1); end
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL phase_stb_count got=%0d exp=1", q_data.size());
        end else begin
            total++;
            if (q_data[0] !== 8'hAA || q_valid[0] !== 1'b1 || q_cyc[0] != n + 9) begin
                bad++; $display("FAIL phase_byte got=%h/%b@%0d exp=aa/1@%0d", q_data[0], q_valid[0], q_cyc[0], n + 9);
            end
        end
    endtask

    task automatic test_broken_lock();
        int n;
        pulse_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h3C);
        send_bit(1'b1);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL broken_after_3c got=%b exp=0", active); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 2; i++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL broken_needs_full_run got=%b exp=0", active); end
        send_byte(8'hBC);
        n = cyc;
        send_byte(8'h55);
        send_byte(8'hBC);
        total++;
        if (act_cyc != n + 1) begin bad++; $display("FAIL broken_active_time got=%0d exp=%0d", act_cyc, n + 1); end
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL broken_stb_count got=%0d exp=1", q_data.size());
        end else begin
            total++;
            if (q_data[0] !== 8'h55 || q_valid[0] !== 1'b1 || q_cyc[0] != n + 9) begin
                bad++; $display("FAIL broken_byte got=%h/%b@%0d exp=55/1@%0d", q_data[0], q_valid[0], q_cyc[0], n + 9);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        send_byte(8'hAA);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        total++;
        if (data_out !== 8'hAA || valid_out !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=%h/%b exp=aa/1", data_out, valid_out);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (data_out !== 8'h00 || valid_out !== 1'b0 || data_stb !== 1'b0 || active !== 1'b0) begin
            bad++; $display("FAIL mid_async_clear got=%h/%b/%b/%b exp=00/0/0/0", data_out, valid_out, data_stb, active);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        total++;
        if (active !== 1'b0 || q_data.size() != 0) begin
            bad++; $display("FAIL mid_relock_early got=%b/%0d exp=0/0", active, q_data.size());
        end
        send_byte(8'hBC);
        n = cyc;
        send_byte(8'h12);
        send_byte(8'hBC);
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL mid_stb_count got=%0d exp=1", q_data.size());
        end else begin
            total++;
            if (q_data[0] !== 8'h12 || q_valid[0] !== 1'b1 || q_cyc[0] != n + 9) begin
                bad++; $display("FAIL mid_byte got=%h/%b@%0d exp=12/1@%0d", q_data[0], q_valid[0], q_cyc[0], n + 9);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        data_in = 1'b0;
        test_reset();
        test_clean_lock();
        test_invalid_slot();
        test_phase_offset();
        test_broken_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side counterpart of the lane parallel-to-serial transmitter.
- Samples one serial bit per clk, MSB first, and finds byte alignment by hunting for the idle comma 8'hBC.
- Declares the lane active after LOCK_COUNT consecutive aligned commas.
- Once active, delivers recovered bytes with a valid flag: comma bytes mean "no data" (valid low).

Parameters:
- COMMA, 8'hBC, idle/alignment symbol the transmitter inserts when in_valid=0.
- LOCK_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
- clk  input  1  bit-rate clock; data_in sampled on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- data_in  input  1  serial bit stream, MSB of each byte first.
- data_out  output  8  last recovered byte; held between byte boundaries.
- valid_out  output  1  1 when data_out is a non-comma byte received in ACTIVE.
- data_stb  output  1  one-clk pulse each time data_out/valid_out update.
- active  output  1  1 while in ACTIVE state.

Behaviour:
- Reset (reset=0, async): data_out=8'h00, valid_out=0, data_stb=0, active=0, shift register=8'h00, bit_cnt=0, bc_cnt=0, state=SEARCH.
- Shift register: sr <= {sr[6:0], data_in} on every clk edge, in every state.
- bit_cnt: 3-bit, counts modulo 8 and wraps 7->0. A byte boundary is any cycle with bit_cnt==0 while in LOCKING or ACTIVE.
- SEARCH:
  - Compare sr to COMMA on every cycle, i.e. at every bit offset.
  - On match: bc_cnt<=1 and bit_cnt<=1, which makes the next boundary exactly 8 clks later.
  - If LOCK_COUNT==1, go straight to ACTIVE; otherwise go to LOCKING.
- LOCKING, at each boundary:
  - sr==COMMA: bc_cnt++. When the new value equals LOCK_COUNT, go to ACTIVE.
  - sr!=COMMA: bc_cnt<=0, return to SEARCH. Bit search resumes on the next cycle.
  - Outputs stay at reset values throughout LOCKING.
- ACTIVE, at each boundary (registered, 1 clk after sr holds the full byte):
  - data_out<=sr.
  - valid_out<=(sr!=COMMA).
  - data_stb<=1 for one clk.
  - Latency: last bit of a byte sampled at edge N -> outputs update at edge N+1.
  - Between boundaries, data_out and valid_out hold their values and data_stb=0.
- active=1 from the edge that enters ACTIVE.
- ACTIVE is sticky until reset. No realignment on a comma seen at an unaligned offset.
- The first boundary in ACTIVE is the byte following the final locking comma.
- Commas received in ACTIVE: data_out=8'hBC, valid_out=0, data_stb still pulses.
- Non-comma bits before the first comma (arbitrary phase offset, 0..7 junk bits or more) are ignored.
- Reset asserted mid-byte or mid-lock: immediate clear as above. After release, alignment restarts from SEARCH; no partial byte is ever output.
- A comma formed across a byte boundary during LOCKING is not counted. Only aligned comparisons count.

Test Plan:
- Reset check: hold reset=0 for 5 bytes of 8'hFF bits -> all outputs 0, state SEARCH; drive 8'hBC bits while reset=0 -> still no lock.
- Clean lock: after release, send BC x4, then AA, EE, EE -> active rises 1 clk after the 4th BC's last bit; data_out/valid_out = AA/1, EE/1, EE/1, each with one data_stb pulse 8 clks apart.
- Invalid-slot comma: in ACTIVE, send BC then BB (transmitter's CC slot with in_valid=0, followed by valid BB) -> BC/valid 0 with strobe, then BB/valid 1.
- Phase offset: prepend 3 junk bits (1,0,1) before BC x4, AA -> lock and AA recovered correctly, identical timing relative to the first comma.
- Broken lock: BC, BC, 8'h3C, then BC x4, 55 -> returns to SEARCH after 3C with active=0; locks on the later run; 55 output valid.
- Reset mid-operation: assert reset 3 bits into the byte after AA in ACTIVE -> outputs clear asynchronously (before the next clk edge); after release, BC x4 is required again before data appears.
